// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the controller state encoding used by the top level.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, compare against the divisor and subtract when it fits.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted_s;
  logic           ge_s;

  // Shift/compare/subtract; the extra top bit keeps the compare exact when
  // the shifted remainder overflows WIDTH bits.
  always_comb begin
    shifted_s = {rem, q[WIDTH-1]};
    ge_s      = (shifted_s >= {1'b0, divisor});
    q_next    = {q[WIDTH-2:0], ge_s};
    if (ge_s) begin
      rem_next = shifted_s[WIDTH-1:0] - divisor;
    end else begin
      rem_next = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle integer divider, one restoring step per clock, with signed mode,
// remainder output, divide-by-zero detection and a busy flag. WIDTH: 4..64.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] x_bi,
  input  logic [WIDTH-1:0] y_bi,
  input  logic             signed_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] y_bo,
  output logic [WIDTH-1:0] r_bo,
  output logic             rdy_o,
  output logic             busy_o,
  output logic             dz_o
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_r;
  state_t           state_s;
  logic             load_s;
  logic             step_s;
  logic             fix_s;
  logic             signed_s;
  logic             xneg_s;
  logic             yneg_s;
  logic             yzero_s;
  logic [WIDTH-1:0] xabs_s;
  logic [WIDTH-1:0] yabs_s;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] qfix_s;
  logic [WIDTH-1:0] rfix_s;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] x_r;
  logic [CW-1:0]    cnt_r;
  logic             negq_r;
  logic             negr_r;
  logic             dz_r;

  // Operand magnitudes; MIN wraps onto itself, which is the correct magnitude
  // when read as unsigned.
  always_comb begin
    signed_s = (SIGNED_EN != 0) && signed_i;
    xneg_s   = signed_s & x_bi[WIDTH-1];
    yneg_s   = signed_s & y_bi[WIDTH-1];
    yzero_s  = (y_bi == {WIDTH{1'b0}});
    if (xneg_s) begin
      xabs_s = -x_bi;
    end else begin
      xabs_s = x_bi;
    end
    if (yneg_s) begin
      yabs_s = -y_bi;
    end else begin
      yabs_s = y_bi;
    end
  end

  // Sign fix-up of the magnitude result.
  always_comb begin
    if (negq_r) begin
      qfix_s = -q_r;
    end else begin
      qfix_s = q_r;
    end
    if (negr_r) begin
      rfix_s = -rem_r;
    end else begin
      rfix_s = rem_r;
    end
  end

  seq_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (div_r),
    .rem_next (rem_nxt_s),
    .q_next   (q_nxt_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i && yzero_s) begin
          state_s = ST_FIX;
        end else if (start_i) begin
          state_s = ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath controls decoded from the state.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    fix_s  = 1'b0;
    case (state_r)
      ST_IDLE: load_s = start_i;
      ST_CALC: step_s = 1'b1;
      ST_FIX:  fix_s  = 1'b1;
      default: fix_s  = 1'b0;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_r  <= {WIDTH{1'b0}};
      q_r    <= {WIDTH{1'b0}};
      div_r  <= {WIDTH{1'b0}};
      x_r    <= {WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
      negq_r <= 1'b0;
      negr_r <= 1'b0;
      dz_r   <= 1'b0;
      y_bo   <= {WIDTH{1'b0}};
      r_bo   <= {WIDTH{1'b0}};
      rdy_o  <= 1'b0;
      busy_o <= 1'b0;
      dz_o   <= 1'b0;
    end else if (load_s) begin
      rem_r  <= {WIDTH{1'b0}};
      q_r    <= xabs_s;
      div_r  <= yabs_s;
      x_r    <= x_bi;
      cnt_r  <= CW'(WIDTH - 1);
      negq_r <= xneg_s ^ yneg_s;
      negr_r <= xneg_s;
      dz_r   <= yzero_s;
      rdy_o  <= 1'b0;
      busy_o <= 1'b1;
      dz_o   <= 1'b0;
    end else if (step_s) begin
      rem_r <= rem_nxt_s;
      q_r   <= q_nxt_s;
      cnt_r <= cnt_r - CW'(1);
    end else if (fix_s) begin
      // Divide by zero reports all ones and hands back the raw dividend.
      if (dz_r) begin
        y_bo <= {WIDTH{1'b1}};
        r_bo <= x_r;
      end else begin
        y_bo <= qfix_s;
        r_bo <= rfix_s;
      end
      dz_o   <= dz_r;
      rdy_o  <= 1'b1;
      busy_o <= 1'b0;
    end else begin
      rdy_o <= rdy_o;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: a 32-bit instance for the
// scenario tests and an 8-bit instance checked against a reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x32 = 32'd0, y32 = 32'd0, q32, r32;
  logic        s32 = 1'b0, st32 = 1'b0, rdy32, busy32, dz32;
  logic [7:0]  x8 = 8'd0, y8 = 8'd0, q8, r8;
  logic        s8 = 1'b0, st8 = 1'b0, rdy8, busy8, dz8;
  int          vec = 0;
  int          miss = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32), .SIGNED_EN(1)) dut32 (
    .clk_i(clk), .rst_i(rst), .x_bi(x32), .y_bi(y32), .signed_i(s32), .start_i(st32),
    .y_bo(q32), .r_bo(r32), .rdy_o(rdy32), .busy_o(busy32), .dz_o(dz32));

  seq_divider #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
    .clk_i(clk), .rst_i(rst), .x_bi(x8), .y_bi(y8), .signed_i(s8), .start_i(st8),
    .y_bo(q8), .r_bo(r8), .rdy_o(rdy8), .busy_o(busy8), .dz_o(dz8));

  // Pulse start for one edge at a negedge, then count edges after acceptance until rdy.
  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic s, output int n);
    x32 = x; y32 = y; s32 = s; st32 = 1'b1;
    @(posedge clk); @(negedge clk);
    st32 = 1'b0;
    n = 0;
    while (rdy32 !== 1'b1 && n < 100) begin
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s, output int n);
    x8 = x; y8 = y; s8 = s; st8 = 1'b1;
    @(posedge clk); @(negedge clk);
    st8 = 1'b0;
    n = 0;
    while (rdy8 !== 1'b1 && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec++; if (q32 !== 32'd0) begin miss++; $display("FAIL reset_q got=%h exp=0", q32); end
    vec++; if (r32 !== 32'd0) begin miss++; $display("FAIL reset_r got=%h exp=0", r32); end
    vec++; if (rdy32 !== 1'b0) begin miss++; $display("FAIL reset_rdy got=%b exp=0", rdy32); end
    vec++; if (busy32 !== 1'b0) begin miss++; $display("FAIL reset_busy got=%b exp=0", busy32); end
    vec++; if (dz32 !== 1'b0) begin miss++; $display("FAIL reset_dz got=%b exp=0", dz32); end
  endtask

  task automatic test_unsigned();
    int n;
    run32(32'd8, 32'd2, 1'b0, n);
    vec++; if (n !== 33) begin miss++; $display("FAIL u_latency got=%0d exp=33", n); end
    vec++; if (q32 !== 32'd4) begin miss++; $display("FAIL u_8div2_q got=%h exp=4", q32); end
    vec++; if (r32 !== 32'd0) begin miss++; $display("FAIL u_8div2_r got=%h exp=0", r32); end
    vec++; if (dz32 !== 1'b0) begin miss++; $display("FAIL u_8div2_dz got=%b exp=0", dz32); end
    vec++; if (busy32 !== 1'b0) begin miss++; $display("FAIL u_busy_done got=%b exp=0", busy32); end
    run32(32'hFFFF_FFFF, 32'd16, 1'b0, n);
    vec++; if (q32 !== 32'h0FFF_FFFF) begin miss++; $display("FAIL u_big_q got=%h exp=0fffffff", q32); end
    vec++; if (r32 !== 32'd15) begin miss++; $display("FAIL u_big_r got=%h exp=f", r32); end
  endtask

  task automatic test_signed();
    int n;
    run32(-32'sd7, 32'd2, 1'b1, n);
    vec++; if (q32 !== -32'sd3) begin miss++; $display("FAIL s_m7div2_q got=%h exp=fffffffd", q32); end
    vec++; if (r32 !== -32'sd1) begin miss++; $display("FAIL s_m7div2_r got=%h exp=ffffffff", r32); end
    run32(32'd7, -32'sd2, 1'b1, n);
    vec++; if (q32 !== -32'sd3) begin miss++; $display("FAIL s_7divm2_q got=%h exp=fffffffd", q32); end
    vec++; if (r32 !== 32'd1) begin miss++; $display("FAIL s_7divm2_r got=%h exp=1", r32); end
    run32(-32'sd7, -32'sd2, 1'b1, n);
    vec++; if (q32 !== 32'd3) begin miss++; $display("FAIL s_m7divm2_q got=%h exp=3", q32); end
    vec++; if (r32 !== -32'sd1) begin miss++; $display("FAIL s_m7divm2_r got=%h exp=ffffffff", r32); end
  endtask

  task automatic test_div_zero();
    int n;
    for (int m = 0; m < 2; m++) begin
      run32(32'd5, 32'd0, m[0], n);
      vec++; if (n !== 1) begin miss++; $display("FAIL dz_latency mode=%0d got=%0d exp=1", m, n); end
      vec++; if (q32 !== 32'hFFFF_FFFF) begin miss++; $display("FAIL dz_q mode=%0d got=%h exp=ffffffff", m, q32); end
      vec++; if (r32 !== 32'd5) begin miss++; $display("FAIL dz_r mode=%0d got=%h exp=5", m, r32); end
      vec++; if (dz32 !== 1'b1) begin miss++; $display("FAIL dz_flag mode=%0d got=%b exp=1", m, dz32); end
    end
    x32 = 32'd9; y32 = 32'd1; s32 = 1'b0; st32 = 1'b1;
    @(posedge clk); @(negedge clk);
    st32 = 1'b0;
    vec++; if (dz32 !== 1'b0) begin miss++; $display("FAIL dz_clear_on_start got=%b exp=0", dz32); end
    vec++; if (rdy32 !== 1'b0) begin miss++; $display("FAIL rdy_drop_on_start got=%b exp=0", rdy32); end
    n = 0;
    while (rdy32 !== 1'b1 && n < 100) begin @(posedge clk); @(negedge clk); n++; end
    vec++; if (q32 !== 32'd9) begin miss++; $display("FAIL dz_next_q got=%h exp=9", q32); end
  endtask

  task automatic test_overflow();
    int n;
    run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, n);
    vec++; if (q32 !== 32'h8000_0000) begin miss++; $display("FAIL ovf_q got=%h exp=80000000", q32); end
    vec++; if (r32 !== 32'd0) begin miss++; $display("FAIL ovf_r got=%h exp=0", r32); end
    vec++; if (dz32 !== 1'b0) begin miss++; $display("FAIL ovf_dz got=%b exp=0", dz32); end
  endtask

  task automatic test_busy_ignore();
    int n;
    x32 = 32'd100; y32 = 32'd7; s32 = 1'b0; st32 = 1'b1;
    @(posedge clk); @(negedge clk);
    st32 = 1'b0;
    n = 0;
    repeat (5) begin @(posedge clk); @(negedge clk); n++; end
    x32 = 32'd1; y32 = 32'd1; st32 = 1'b1;
    @(posedge clk); @(negedge clk); n++;
    st32 = 1'b0;
    vec++; if (busy32 !== 1'b1) begin miss++; $display("FAIL busy_mid_calc got=%b exp=1", busy32); end
    while (rdy32 !== 1'b1 && n < 100) begin @(posedge clk); @(negedge clk); n++; end
    vec++; if (n !== 33) begin miss++; $display("FAIL ignore_latency got=%0d exp=33", n); end
    vec++; if (q32 !== 32'd14) begin miss++; $display("FAIL ignore_q got=%h exp=e", q32); end
    vec++; if (r32 !== 32'd2) begin miss++; $display("FAIL ignore_r got=%h exp=2", r32); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    x32 = 32'd100; y32 = 32'd7; s32 = 1'b0; st32 = 1'b1;
    @(posedge clk); @(negedge clk);
    st32 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    vec++; if (q32 !== 32'd0) begin miss++; $display("FAIL rstmid_q got=%h exp=0", q32); end
    vec++; if (r32 !== 32'd0) begin miss++; $display("FAIL rstmid_r got=%h exp=0", r32); end
    vec++; if (busy32 !== 1'b0) begin miss++; $display("FAIL rstmid_busy got=%b exp=0", busy32); end
    vec++; if ({rdy32, dz32} !== 2'b00) begin miss++; $display("FAIL rstmid_rdy_dz got=%b exp=00", {rdy32, dz32}); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (rdy32 === 1'b1) seen = 1'b1; end
    vec++; if (seen !== 1'b0) begin miss++; $display("FAIL rstmid_no_result got=%b exp=0", seen); end
    run32(32'd8, 32'd2, 1'b0, n);
    vec++; if (q32 !== 32'd4 || n !== 33) begin miss++; $display("FAIL rstmid_restart got=%h/%0d exp=4/33", q32, n); end
  endtask

  task automatic test_back_to_back();
    int n;
    x32 = 32'd20; y32 = 32'd3; s32 = 1'b0; st32 = 1'b1;
    @(posedge clk); @(negedge clk);
    n = 0;
    while (rdy32 !== 1'b1 && n < 100) begin @(posedge clk); @(negedge clk); n++; end
    vec++; if (n !== 33) begin miss++; $display("FAIL b2b_first_latency got=%0d exp=33", n); end
    vec++; if (q32 !== 32'd6 || r32 !== 32'd2) begin miss++; $display("FAIL b2b_first got=%h/%h exp=6/2", q32, r32); end
    @(posedge clk); @(negedge clk);
    vec++; if (rdy32 !== 1'b0 || busy32 !== 1'b1) begin miss++; $display("FAIL b2b_restart rdy/busy got=%b%b exp=01", rdy32, busy32); end
    n = 0;
    while (rdy32 !== 1'b1 && n < 100) begin @(posedge clk); @(negedge clk); n++; end
    st32 = 1'b0;
    vec++; if (n !== 33) begin miss++; $display("FAIL b2b_second_latency got=%0d exp=33", n); end
    @(posedge clk); @(negedge clk);
    vec++; if (rdy32 !== 1'b1 || q32 !== 32'd6) begin miss++; $display("FAIL b2b_hold got=%b/%h exp=1/6", rdy32, q32); end
  endtask

  task automatic test_width8_model();
    int n, xi, yi, qi, ri;
    logic [7:0] xa, ya, eq, er;
    logic sm, edz;
    for (int i = 0; i < 1000; i++) begin
      xa = 8'($urandom_range(0, 255));
      ya = 8'($urandom_range(0, 255));
      sm = 1'($urandom_range(0, 1));
      if (i % 16 == 0) ya = 8'd0;
      if (i % 16 == 8) begin xa = 8'h80; ya = 8'hFF; sm = 1'b1; end
      if (ya == 8'd0) begin
        eq = 8'hFF; er = xa; edz = 1'b1;
      end else begin
        if (sm) begin xi = $signed(xa); yi = $signed(ya); end
        else begin xi = int'(xa); yi = int'(ya); end
        qi = xi / yi; ri = xi % yi;
        eq = qi[7:0]; er = ri[7:0]; edz = 1'b0;
      end
      run8(xa, ya, sm, n);
      vec++; if (n !== (edz ? 1 : 9)) begin miss++; $display("FAIL w8_latency x=%h y=%h s=%b got=%0d", xa, ya, sm, n); end
      vec++; if (q8 !== eq) begin miss++; $display("FAIL w8_q x=%h y=%h s=%b got=%h exp=%h", xa, ya, sm, q8, eq); end
      vec++; if (r8 !== er) begin miss++; $display("FAIL w8_r x=%h y=%h s=%b got=%h exp=%h", xa, ya, sm, r8, er); end
      vec++; if (dz8 !== edz) begin miss++; $display("FAIL w8_dz x=%h y=%h s=%b got=%b exp=%b", xa, ya, sm, dz8, edz); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_width8_model();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
